// File: rtl/reg_file_wb_pkg.sv
// Shared sizing constants and reset value for the reg_file_wb register file slice.
package reg_file_wb_pkg;

   localparam int DATA_WIDTH    = 8;
   localparam int ADDR_WIDTH    = 3;
   localparam int NUM_REGS      = 8;
   localparam int REG_RESET_VAL = 0;

endpackage : reg_file_wb_pkg

// File: rtl/reg_file_wb_wb.sv
// Write-back stage: one-entry valid/addr/data pipeline register with synchronous reset.
module wb_stage
   import reg_file_wb_pkg::*;
#(
   parameter int DATA_WIDTH = reg_file_wb_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = reg_file_wb_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  captureValid,
   input  logic [ADDR_WIDTH-1:0] captureAddr,
   input  logic [DATA_WIDTH-1:0] captureData,
   output logic                  wbValid,
   output logic [ADDR_WIDTH-1:0] wbAddr,
   output logic [DATA_WIDTH-1:0] wbData
);

   always_ff @(posedge clk) begin
      if (reset) begin
         wbValid <= 1'b0;
         wbAddr  <= '0;
         wbData  <= DATA_WIDTH'(REG_RESET_VAL);
      end else begin
         wbValid <= captureValid;
         wbAddr  <= captureAddr;
         wbData  <= captureData;
      end
   end

endmodule : wb_stage

// File: rtl/reg_file_wb.sv
// 8x8 register file with registered write-back, read-port bypass and ZERO flag.
// Optional: define REG0_HARDWIRED_EN to make register 0 read as zero and ignore writes to it.
module reg_file_wb
   import reg_file_wb_pkg::*;
#(
   parameter int DATA_WIDTH = reg_file_wb_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = reg_file_wb_pkg::ADDR_WIDTH,
   parameter int NUM_REGS   = reg_file_wb_pkg::NUM_REGS
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [DATA_WIDTH-1:0] IN,
   input  logic [ADDR_WIDTH-1:0] INADDRESS,
   input  logic                  WRITE,
   input  logic                  ZERO_IN,
   input  logic                  FLAG_WRITE,
   input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
   input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
   output logic [DATA_WIDTH-1:0] OUT1,
   output logic [DATA_WIDTH-1:0] OUT2,
   output logic                  ZERO_FLAG,
   output logic                  WB_PENDING
);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  captureValid;
   logic                  wbValid;
   logic [ADDR_WIDTH-1:0] wbAddr;
   logic [DATA_WIDTH-1:0] wbData;

   always_comb begin
      captureValid = WRITE;
`ifdef REG0_HARDWIRED_EN
      if (INADDRESS == '0) captureValid = 1'b0;
`endif
   end

   wb_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) wbStage (
      .clk          (CLK),
      .reset        (RESET),
      .captureValid (captureValid),
      .captureAddr  (INADDRESS),
      .captureData  (IN),
      .wbValid      (wbValid),
      .wbAddr       (wbAddr),
      .wbData       (wbData)
   );

   // Commit happens on the edge after capture; a pending entry is dropped on reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= DATA_WIDTH'(REG_RESET_VAL);
      end else if (wbValid) begin
         regs[wbAddr] <= wbData;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET)           ZERO_FLAG <= 1'b0;
      else if (FLAG_WRITE) ZERO_FLAG <= ZERO_IN;
   end

   always_comb begin
      OUT1 = regs[OUT1ADDRESS];
      OUT2 = regs[OUT2ADDRESS];
      if (wbValid && (wbAddr == OUT1ADDRESS)) OUT1 = wbData;
      if (wbValid && (wbAddr == OUT2ADDRESS)) OUT2 = wbData;
`ifdef REG0_HARDWIRED_EN
      if (OUT1ADDRESS == '0) OUT1 = '0;
      if (OUT2ADDRESS == '0) OUT2 = '0;
`endif
   end

   assign WB_PENDING = wbValid;

endmodule : reg_file_wb

// File: tb/tb_reg_file_wb.sv
// Self-checking bench for reg_file_wb: directed scenarios plus random traffic against a visibility model.
module tb_reg_file_wb;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [7:0] IN = '0;
   logic [2:0] INADDRESS = '0;
   logic       WRITE = 1'b0;
   logic       ZERO_IN = 1'b0;
   logic       FLAG_WRITE = 1'b0;
   logic [2:0] OUT1ADDRESS = '0;
   logic [2:0] OUT2ADDRESS = '0;
   logic [7:0] OUT1;
   logic [7:0] OUT2;
   logic       ZERO_FLAG;
   logic       WB_PENDING;

   int total = 0;
   int bad   = 0;

   // Architectural view: a write is readable right after its capture edge.
   int  modelMem [8];
   bit  modelPend;
   bit  modelZf;

   reg_file_wb #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (3),
      .NUM_REGS   (8)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .IN          (IN),
      .INADDRESS   (INADDRESS),
      .WRITE       (WRITE),
      .ZERO_IN     (ZERO_IN),
      .FLAG_WRITE  (FLAG_WRITE),
      .OUT1ADDRESS (OUT1ADDRESS),
      .OUT2ADDRESS (OUT2ADDRESS),
      .OUT1        (OUT1),
      .OUT2        (OUT2),
      .ZERO_FLAG   (ZERO_FLAG),
      .WB_PENDING  (WB_PENDING)
   );

   always #5 CLK = ~CLK;

   task automatic checkVal(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int expRead(input int addr);
`ifdef REG0_HARDWIRED_EN
      if (addr == 0) return 0;
`endif
      return modelMem[addr];
   endfunction

   // Drive one cycle's inputs, clock them in and advance the model.
   task automatic cycle(input bit rst, input bit wr, input int addr, input int data,
                        input bit fw, input bit zin);
      RESET      = rst;
      WRITE      = wr;
      INADDRESS  = 3'(addr);
      IN         = 8'(data);
      FLAG_WRITE = fw;
      ZERO_IN    = zin;
      @(posedge CLK);
      if (rst) begin
         foreach (modelMem[i]) modelMem[i] = 0;
         modelPend = 0;
         modelZf   = 0;
      end else begin
         bit effWr = wr;
`ifdef REG0_HARDWIRED_EN
         if (addr == 0) effWr = 0;
`endif
         if (effWr) modelMem[addr] = data;
         modelPend = effWr;
         if (fw) modelZf = zin;
      end
      #2;
      RESET = 1'b0;
      WRITE = 1'b0;
      FLAG_WRITE = 1'b0;
   endtask

   task automatic checkPorts(input string tag, input int a1, input int a2);
      OUT1ADDRESS = 3'(a1);
      OUT2ADDRESS = 3'(a2);
      #1;
      checkVal({tag, ".out1"}, int'(OUT1), expRead(a1));
      checkVal({tag, ".out2"}, int'(OUT2), expRead(a2));
      checkVal({tag, ".pend"}, int'(WB_PENDING), int'(modelPend));
      checkVal({tag, ".zf"}, int'(ZERO_FLAG), int'(modelZf));
   endtask

   initial begin
      foreach (modelMem[i]) modelMem[i] = 0;
      modelPend = 0;
      modelZf   = 0;

      // Reset held for two edges, then every address reads zero.
      cycle(1, 1, 4, 8'h99, 1, 1);
      cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) checkPorts("reset", i, 7 - i);
      checkVal("reset.const", int'(OUT1), 0);

      // Single write: bypass in the following cycle, then committed value.
      cycle(0, 1, 3, 8'h5A, 0, 0);
      checkPorts("wr3.bypass", 3, 0);
      checkVal("wr3.pendHigh", int'(WB_PENDING), 1);
      cycle(0, 0, 0, 0, 0, 0);
      checkPorts("wr3.commit", 3, 3);
      checkVal("wr3.value", int'(OUT1), 8'h5A);

      // Back-to-back writes to the same register: last one wins.
      cycle(0, 1, 2, 8'h11, 0, 0);
      checkPorts("r2.first", 0, 2);
      cycle(0, 1, 2, 8'h22, 0, 0);
      checkPorts("r2.second", 2, 2);
      checkVal("r2.value", int'(OUT2), 8'h22);
      cycle(0, 0, 0, 0, 0, 0);
      checkPorts("r2.after", 2, 2);

      // Reset on the commit edge discards the pending write.
      cycle(0, 1, 5, 8'hFF, 0, 0);
      checkPorts("r5.pending", 5, 5);
      cycle(1, 0, 0, 0, 0, 0);
      checkPorts("r5.reset", 5, 3);
      checkVal("r5.zero", int'(OUT1), 0);

      // ZERO flag capture and hold.
      cycle(0, 0, 0, 0, 1, 1);
      checkPorts("zf.set", 1, 2);
      checkVal("zf.one", int'(ZERO_FLAG), 1);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 0, 0, 0);
         checkPorts("zf.hold", 0, 1);
      end

      // Register 0 write (hardwired or ordinary depending on build).
      cycle(0, 1, 0, 8'h7C, 0, 0);
      checkPorts("r0.capture", 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      checkPorts("r0.after", 0, 0);
`ifdef REG0_HARDWIRED_EN
      checkVal("r0.hard", int'(OUT1), 0);
`else
      checkVal("r0.plain", int'(OUT1), 8'h7C);
`endif

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
               int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         checkPorts("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_reg_file_wb
